instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Upstream stage of the vector CPU. Holds a small program RAM of 9-bit vector instructions
//  (load/store/ALU) and issues them one per cycle on `instruction`.
//  - The CPU consumes an instruction only when instr_valid=1 and stall=0.
//  - The CPU gates its register-file and memory write enables with instr_valid.
//  - Run control: start / done, plus a simple stall handshake.
// PARAMETERS
//  INSTR_W   9                 instruction width; fields [8:7] op, [6:5] rs, [4:0] addr
//  DEPTH     32                program RAM entries
//  ADDR_W    $clog2(DEPTH)     PC / RAM address width
// PORTS
//  clk          in   1         clock; all state changes on posedge
//  rst          in   1         synchronous, active-high reset
//  prog_we      in   1         program RAM write strobe; honoured only in IDLE or DONE
//  prog_addr    in   ADDR_W    program RAM write address
//  prog_data    in   INSTR_W   program RAM write data
//  prog_len     in   ADDR_W+1  number of instructions to run (0..DEPTH); sampled on start
//  start        in   1         begin execution at address 0; honoured only in IDLE or DONE
//  stall        in   1         downstream not ready; hold the current issue
//  instruction  out  INSTR_W   registered instruction to the CPU
//  instr_valid  out  1         instruction is live
//  pc           out  ADDR_W    RAM address of the instruction currently presented
//  busy         out  1         state == RUN
//  done         out  1         state == DONE (level; cleared by start or rst)
// BEHAVIOUR
//  Reset
//   - Sync rst -> state IDLE; instruction=0, instr_valid=0, pc=0, busy=0, done=0.
//   - RAM contents are NOT reset.
//   - rst mid-RUN aborts immediately; no further issue.
//  FSM: IDLE -> RUN -> DONE -> (start) RUN
//   - IDLE/DONE + start, prog_len>0: latch len. Next cycle: RUN, instruction=ram[0], instr_valid=1, pc=0, done=0.
//   - IDLE/DONE + start, prog_len==0: next cycle DONE, done=1, instr_valid stays 0.
//   - RUN, stall=1: instruction, instr_valid and pc all hold.
//   - RUN, stall=0, pc<len-1: pc+1, instruction=ram[pc+1]. One instruction per cycle, zero bubbles.
//   - RUN, stall=0, pc==len-1: next cycle DONE, instr_valid=0, instruction=0, pc holds.
//   - start asserted during RUN is ignored.
//  Handshake
//   - An issue is consumed on any cycle with instr_valid & ~stall.
//   - Exactly len consumptions per run.
//   - Latency from start to first valid instruction: 1 cycle.
//  Program RAM
//   - Synchronous write; read feeds the instruction register.
//   - prog_we in RUN is dropped: no write, no error.
//   - prog_we and start in the same cycle: write commits; the first fetch reads the pre-write
//     contents (read-before-write).
//  Widths: prog_len==DEPTH is legal; the pc compare uses ADDR_W+1 bits, so no wrap-around.
// STRUCTURE
//  - Shared package vp_pkg: INSTR_W, OP_LOAD=2'b00, OP_STORE=2'b01, ALU marker bit 8,
//    field slice localparams, sequencer state enum {S_IDLE,S_RUN,S_DONE}.
//  - One sub-module, prog_ram: DEPTH x INSTR_W, 1 write port, 1 combinational read port.
//  - FSM, pc counter and output registers live in instr_sequencer.
// TESTING
//  1. Load 3 words 0x01F,0x0A5,0x180, prog_len=3, start
//     -> instruction 0x01F,0x0A5,0x180 on 3 consecutive cycles, valid=1, pc=0,1,2; then done=1, valid=0.
//  2. Same program, stall=1 on the cycle pc=1 is presented, for 2 cycles
//     -> 0x0A5 held 3 cycles total, pc=1 held; exactly 3 consumptions counted.
//  3. prog_len=0, start -> done=1 the next cycle; instr_valid never 1.
//  4. rst asserted while pc=1 in RUN -> next cycle all outputs 0, IDLE.
//     Restart without reloading -> same 3 words replay (RAM preserved).
//  5. prog_we to addr 0 during RUN -> ignored; rerun still issues old word.
//     prog_we addr0=0x1FF together with start -> first issue is old word;
//     the next run issues 0x1FF.
//  6. DEPTH=32, prog_len=32 -> 32 valid issues, pc 0..31, no wrap; done after the 32nd.

Source files
------------

// File: rtl/vp_pkg.sv
// Shared vector-CPU definitions: instruction geometry, opcode markers and the
// sequencer state encoding.
package vp_pkg;

    localparam int INSTR_W = 9;
    localparam int DEPTH   = 32;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int LEN_W   = ADDR_W + 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam int         ALU_BIT  = 8;

    localparam int OP_HI   = 8;
    localparam int OP_LO   = 7;
    localparam int RS_HI   = 6;
    localparam int RS_LO   = 5;
    localparam int ADDR_HI = 4;
    localparam int ADDR_LO = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

    function automatic logic is_alu(input logic [INSTR_W-1:0] instr);
        return instr[ALU_BIT];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle between the sequencer and its host/CPU side.
// Handshake: an issue is consumed on every cycle where instr_valid=1 and stall=0;
// while stall=1 the sequencer holds instruction, instr_valid and pc unchanged.
interface instr_sequencer_if
    import vp_pkg::*;
#(
    parameter int DEPTH  = vp_pkg::DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic               prog_we;
    logic [ADDR_W-1:0]  prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic [ADDR_W:0]    prog_len;
    logic               start;
    logic               stall;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic [ADDR_W-1:0]  pc;
    logic               busy;
    logic               done;
    seq_state_t         state_dbg;

    modport master (
        input  prog_we, prog_addr, prog_data, prog_len, start, stall,
        output instruction, instr_valid, pc, busy, done, state_dbg
    );

    modport slave (
        output prog_we, prog_addr, prog_data, prog_len, start, stall,
        input  instruction, instr_valid, pc, busy, done, state_dbg
    );
endinterface

// File: rtl/instr_sequencer_prog_ram.sv
// Program store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a program survives an abort.
module prog_ram
    import vp_pkg::*;
#(
    parameter int DEPTH  = vp_pkg::DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues a stored program one instruction per cycle, honouring downstream stall.
// FSM, pc and all outputs are registered here; storage lives in prog_ram.
module instr_sequencer
    import vp_pkg::*;
#(
    parameter int DEPTH  = vp_pkg::DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    instr_sequencer_if.master bus
);

    seq_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    logic [ADDR_W-1:0]  rd_addr;
    logic [INSTR_W-1:0] rd_data;
    logic               ram_we;
    logic [LEN_W-1:0]   last_idx;
    logic               at_last;

    // Writes are only accepted while nothing is being fetched.
    assign ram_we   = bus.prog_we && (state_q != S_RUN);
    // Fetch address is one ahead of pc while running; the launch fetch is address 0.
    assign rd_addr  = (state_q == S_RUN) ? (pc_q + ADDR_W'(1)) : '0;
    assign last_idx = len_q - LEN_W'(1);
    assign at_last  = ({1'b0, pc_q} == last_idx);

    prog_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_prog_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        instr_d = instr_q;
        valid_d = valid_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    pc_d = '0;
                    if (bus.prog_len != '0) begin
                        len_d   = bus.prog_len;
                        state_d = S_RUN;
                        instr_d = rd_data;
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        instr_d = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (!bus.stall) begin
                    if (at_last) begin
                        state_d = S_DONE;
                        instr_d = '0;
                        valid_d = 1'b0;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        instr_d = rd_data;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                instr_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = (state_q == S_RUN);
    assign bus.done        = (state_q == S_DONE);
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: expected issues are queued when a run is
// launched and popped by a consumption monitor.
module tb_instr_sequencer;
    import vp_pkg::*;

    localparam int W = ADDR_W + INSTR_W;

    logic clk;
    logic rst;

    instr_sequencer_if #(.DEPTH(DEPTH)) sif ();

    instr_sequencer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.master)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    int n_cons;
    logic [W-1:0]       exp_q[$];
    logic [INSTR_W-1:0] model_ram [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // scoreboard: every consumption pops one {pc, instruction} entry
    always @(negedge clk) begin
        if (!rst && sif.instr_valid === 1'b1 && sif.stall === 1'b0) begin
            n_cons++;
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", 32'(sif.instruction), 32'h0);
                chk("unexpected_issue_valid", 32'(sif.instr_valid), 32'h0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                chk("issue_instr", 32'(sif.instruction), 32'(e[INSTR_W-1:0]));
                chk("issue_pc", 32'(sif.pc), 32'(e[W-1:INSTR_W]));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [INSTR_W-1:0] d);
        sif.prog_we   = 1'b1;
        sif.prog_addr = ADDR_W'(a);
        sif.prog_data = d;
        tick();
        sif.prog_we   = 1'b0;
        model_ram[a]  = d;
    endtask

    // we_mode: 0 none, 1 write addr0 during RUN (dropped), 2 write addr0 with start
    task automatic run_prog(input int len, input int stall_pc, input int stall_n,
                            input int we_mode, input logic [INSTR_W-1:0] we_data);
        int  cons0;
        bit  stalled;
        bit  we_done;
        cons0 = n_cons;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({ADDR_W'(i), model_ram[i]});
        end
        sif.prog_len = (ADDR_W+1)'(len);
        sif.start    = 1'b1;
        if (we_mode == 2) begin
            sif.prog_we   = 1'b1;
            sif.prog_addr = '0;
            sif.prog_data = we_data;
        end
        tick();
        sif.start   = 1'b0;
        sif.prog_we = 1'b0;
        if (we_mode == 2) model_ram[0] = we_data;
        if (len > 0) begin
            chk("launch_valid", 32'(sif.instr_valid), 32'h1);
            chk("launch_pc", 32'(sif.pc), 32'h0);
            chk("launch_busy", 32'(sif.busy), 32'h1);
            chk("launch_done", 32'(sif.done), 32'h0);
        end else begin
            chk("len0_done", 32'(sif.done), 32'h1);
            chk("len0_valid", 32'(sif.instr_valid), 32'h0);
        end
        stalled = 1'b0;
        we_done = 1'b0;
        for (int c = 0; c < 200 && sif.done !== 1'b1; c++) begin
            if (we_mode == 1 && !we_done) begin
                sif.prog_we   = 1'b1;
                sif.prog_addr = '0;
                sif.prog_data = we_data;
                we_done       = 1'b1;
            end
            if (!stalled && stall_n > 0 && sif.pc === ADDR_W'(stall_pc)) begin
                sif.stall = 1'b1;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    sif.prog_we = 1'b0;
                    chk("stall_pc_hold", 32'(sif.pc), 32'(stall_pc));
                    chk("stall_instr_hold", 32'(sif.instruction), 32'(model_ram[stall_pc]));
                    chk("stall_valid_hold", 32'(sif.instr_valid), 32'h1);
                end
                sif.stall = 1'b0;
                stalled   = 1'b1;
            end
            tick();
            sif.prog_we = 1'b0;
        end
        chk("end_done", 32'(sif.done), 32'h1);
        chk("end_valid", 32'(sif.instr_valid), 32'h0);
        chk("end_instr", 32'(sif.instruction), 32'h0);
        chk("end_busy", 32'(sif.busy), 32'h0);
        chk("end_state", 32'(sif.state_dbg), 32'(S_DONE));
        if (len > 0) chk("end_pc_hold", 32'(sif.pc), 32'(len - 1));
        chk("consumptions", 32'(n_cons - cons0), 32'(len));
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_instr"}, 32'(sif.instruction), 32'h0);
        chk({tag, "_valid"}, 32'(sif.instr_valid), 32'h0);
        chk({tag, "_pc"}, 32'(sif.pc), 32'h0);
        chk({tag, "_busy"}, 32'(sif.busy), 32'h0);
        chk({tag, "_done"}, 32'(sif.done), 32'h0);
        chk({tag, "_state"}, 32'(sif.state_dbg), 32'(S_IDLE));
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_cons = 0;
        sif.prog_we = 1'b0; sif.prog_addr = '0; sif.prog_data = '0;
        sif.prog_len = '0; sif.start = 1'b0; sif.stall = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // 1: basic three-word program
        load_word(0, 9'h01F);
        load_word(1, 9'h0A5);
        load_word(2, 9'h180);
        run_prog(3, -1, 0, 0, '0);

        // 2: stall two cycles while pc=1 is presented
        run_prog(3, 1, 2, 0, '0);

        // 3: zero-length program
        run_prog(0, -1, 0, 0, '0);

        // 4: abort mid-run, then replay from preserved RAM
        for (int i = 0; i < 3; i++) exp_q.push_back({ADDR_W'(i), model_ram[i]});
        sif.prog_len = 6'd3;
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        tick();
        chk("pre_abort_pc", 32'(sif.pc), 32'h1);
        rst = 1'b1;
        tick();
        check_reset_outputs("abort");
        rst = 1'b0;
        exp_q.delete();
        tick();
        check_reset_outputs("abort_idle");
        run_prog(3, -1, 0, 0, '0);

        // 5: write during RUN is dropped; write with start is read-before-write
        run_prog(3, -1, 0, 1, 9'h1FF);
        run_prog(3, -1, 0, 0, '0);
        run_prog(3, -1, 0, 2, 9'h1FF);
        chk("ram_commit_word", 32'(model_ram[0]), 32'h1FF);
        run_prog(3, -1, 0, 0, '0);

        // 6: full-depth program, no pc wrap
        for (int i = 0; i < DEPTH; i++) begin
            load_word(i, INSTR_W'($urandom_range(0, (1 << INSTR_W) - 1)));
        end
        run_prog(DEPTH, 17, 1, 0, '0);

        // start during RUN must be ignored
        for (int i = 0; i < 3; i++) exp_q.push_back({ADDR_W'(i), model_ram[i]});
        sif.prog_len = 6'd3;
        sif.start = 1'b1;
        tick();
        tick();
        chk("start_in_run_pc", 32'(sif.pc), 32'h1);
        chk("start_in_run_busy", 32'(sif.busy), 32'h1);
        tick();
        sif.start = 1'b0;
        chk("start_in_run_pc2", 32'(sif.pc), 32'h2);
        tick();
        chk("start_in_run_done", 32'(sif.done), 32'h1);
        chk("start_in_run_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
